// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin sharing of one sqrt unit among NUM_REQ requesters
// Optional watchdog abort enabled by defining SQRT_ARB_WDOG_EN.
module sqrt_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ID_W     = 2,
   parameter int WDOG_CYC = 64
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*64-1:0]  req_num,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [63:0]            rsp_data,
   output logic                   rsp_err,
   output logic                   busy,
   output logic                   sq_enable,
   output logic [63:0]            sq_num_64,
   input  logic                   sq_valid,
   input  logic [63:0]            sq_sqrt_value
);

   localparam int CNT_W = $clog2(WDOG_CYC) + 1;
   localparam int SEL_W = $clog2(NUM_REQ * 64);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(WDOG_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;
   logic [63:0]        sq_num_q, sq_num_d;
   logic [63:0]        rsp_data_q, rsp_data_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

   logic               pick_found;
   logic [ID_W-1:0]    pick_id;
   logic [ID_W-1:0]    cand_id;
   int                 cand;
   logic [SEL_W-1:0]   sel_base;

`ifdef SQRT_ARB_WDOG_EN
   logic               rsp_err_q, rsp_err_d;
`endif

   // Round-robin pick: first set req bit above rr_ptr, wrapping; scanning
   // downward lets the nearest candidate overwrite farther ones.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = 0;
      cand_id    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_id = cand[ID_W-1:0];
         if (req[cand_id]) begin
            pick_found = 1'b1;
            pick_id    = cand_id;
         end
      end
      sel_base = SEL_W'({pick_id, 6'd0});
   end

   // Next-state and datapath decisions for the IDLE/BUSY/GAP sequencer.
   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      rr_ptr_d    = rr_ptr_q;
      busy_cnt_d  = busy_cnt_q;
      sq_num_d    = sq_num_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = '0;
`ifdef SQRT_ARB_WDOG_EN
      rsp_err_d   = rsp_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               sq_num_d   = req_num[sel_base +: 64];
               id_d       = pick_id;
               rr_ptr_d   = pick_id;
               busy_cnt_d = '0;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            // Saturate so the first-cycle detection never re-fires on wrap.
            if (busy_cnt_q != CNT_LIM) begin
               busy_cnt_d = busy_cnt_q + 1'b1;
            end
            if (sq_valid) begin
               rsp_data_d           = sq_sqrt_value;
               rsp_valid_d[id_q]    = 1'b1;
               state_d              = S_GAP;
`ifdef SQRT_ARB_WDOG_EN
               rsp_err_d            = 1'b0;
            end else if (busy_cnt_q == CNT_LIM) begin
               rsp_data_d           = '0;
               rsp_err_d            = 1'b1;
               rsp_valid_d[id_q]    = 1'b1;
               state_d              = S_GAP;
`endif
            end
         end
         S_GAP: begin
            // One enable-low cycle clears the unit's enable-held counter.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= S_IDLE;
         id_q        <= '0;
         rr_ptr_q    <= ID_W'(NUM_REQ - 1);
         busy_cnt_q  <= '0;
         sq_num_q    <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         rr_ptr_q    <= rr_ptr_d;
         busy_cnt_q  <= busy_cnt_d;
         sq_num_q    <= sq_num_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

`ifdef SQRT_ARB_WDOG_EN
   // Error qualifier register for watchdog aborts.
   always_ff @(posedge clk) begin
      if (srst) begin
         rsp_err_q <= 1'b0;
      end else begin
         rsp_err_q <= rsp_err_d;
      end
   end
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Grant pulses during the first BUSY cycle of each job.
   always_comb begin
      gnt = '0;
      if (state_q == S_BUSY && busy_cnt_q == '0) begin
         gnt[id_q] = 1'b1;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign sq_enable = (state_q == S_BUSY);
   assign sq_num_64 = sq_num_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_valid = rsp_valid_q;

endmodule
